// File: rtl/top_debouncer.sv
// ============================================================================
// Module   : top_debouncer
// Brief    : Two-flop synchroniser and stable-time debouncer for one button.
//            Define DEBOUNCE_EDGE_PULSE_EN to add rise_pulse/fall_pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_debouncer #(
    parameter int   CLK_FREQ    = 50,
    parameter int   TIME_DELAY  = 1,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic value_in,
`ifdef DEBOUNCE_EDGE_PULSE_EN
    output logic rise_pulse,
    output logic fall_pulse,
`endif
    output logic value_out
);

    localparam int MAX_CLK_COUNT = TIME_DELAY * CLK_FREQ * 1000;
    localparam int CNT_W         = $clog2(MAX_CLK_COUNT + 1);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_CLK_COUNT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    generate
        if (TIME_DELAY < 1 || CLK_FREQ < 1) begin : g_bad_param
            $error("top_debouncer: TIME_DELAY and CLK_FREQ must both be >= 1");
        end
    endgenerate

    logic             r_sync1;
    logic             r_sync2;
    logic             r_value_out;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_commit;

    assign w_differs = (r_sync2 != r_value_out);
    assign w_commit  = w_differs && (r_count == c_cnt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= RESET_VALUE;
            r_sync2 <= RESET_VALUE;
        end else begin
            r_sync1 <= value_in;
            r_sync2 <= r_sync1;
        end
    end

    // Any cycle agreeing with the output restarts timing from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value_out <= RESET_VALUE;
            r_count     <= '0;
        end else if (!w_differs) begin
            r_count     <= '0;
        end else if (w_commit) begin
            r_value_out <= r_sync2;
            r_count     <= '0;
        end else begin
            r_count     <= r_count + c_cnt_one;
        end
    end

    assign value_out = r_value_out;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic r_rise_pulse;
    logic r_fall_pulse;

    // Pulses are tied to the commit itself, so reset can never raise them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_rise_pulse <= w_commit &&  r_sync2;
            r_fall_pulse <= w_commit && !r_sync2;
        end
    end

    assign rise_pulse = r_rise_pulse;
    assign fall_pulse = r_fall_pulse;
`endif

endmodule

`default_nettype wire

// File: tb/tb_top_debouncer.sv
// ============================================================================
// Module   : tb_top_debouncer
// Brief    : Directed self-checking bench for top_debouncer (1 MHz, 1 ms => N=1000).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_debouncer;

    localparam int N = 1000;

    logic clk;
    logic rst;
    logic value_in;
    logic value_out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_pulse;
    logic fall_pulse;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    top_debouncer #(
        .CLK_FREQ    (1),
        .TIME_DELAY  (1),
        .RESET_VALUE (1'b1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
`ifdef DEBOUNCE_EDGE_PULSE_EN
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
`endif
        .value_out  (value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic exp_rise, input logic exp_fall);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        chk({tag, "_rise"}, rise_pulse, exp_rise);
        chk({tag, "_fall"}, fall_pulse, exp_fall);
`else
        if (tag.len() < 0) $display("%b%b", exp_rise, exp_fall);
`endif
    endtask

    initial begin
        // Reset is asserted from time zero; output must be 1 before any clock edge.
        rst      = 1'b1;
        value_in = 1'b0;
        #1;
        chk("reset_async_init", value_out, 1'b1);
        chk_pulses("reset_init", 1'b0, 1'b0);
        cycles(2);
        value_in = 1'b1;
        rst      = 1'b0;
        cycles(20);
        chk("after_reset_idle", value_out, 1'b1);

        // Short press: 10 cycles low.
        value_in = 1'b0;
        cycles(10);
        value_in = 1'b1;
        cycles(5);
        chk("short_press_mid", value_out, 1'b1);
        cycles(N + 20);
        chk("short_press_end", value_out, 1'b1);

        // Half-delay hold, one-cycle glitch, then hold again.
        value_in = 1'b0;
        cycles(N / 2);
        value_in = 1'b1;
        cycles(1);
        value_in = 1'b0;
        cycles(N - 1);
        chk("glitch_no_accum", value_out, 1'b1);
        cycles(2);
        chk("glitch_edge_N", value_out, 1'b1);
        cycles(1);
        chk("glitch_edge_N1", value_out, 1'b0);
        chk_pulses("fall_edge", 1'b0, 1'b1);
        cycles(1);
        chk("fall_hold", value_out, 1'b0);
        chk_pulses("fall_after", 1'b0, 1'b0);

        // Long hold at 0 with a single-cycle high glitch.
        cycles(N);
        value_in = 1'b1;
        cycles(1);
        value_in = 1'b0;
        cycles(5);
        chk("long_glitch_near", value_out, 1'b0);
        cycles(N + 10);
        chk("long_glitch_far", value_out, 1'b0);
        chk_pulses("long_glitch", 1'b0, 1'b0);

        // Release: 0 -> 1 with identical latency.
        value_in = 1'b1;
        cycles(N + 1);
        chk("release_edge_N", value_out, 1'b0);
        chk_pulses("release_pre", 1'b0, 1'b0);
        cycles(1);
        chk("release_edge_N1", value_out, 1'b1);
        chk_pulses("rise_edge", 1'b1, 1'b0);
        cycles(1);
        chk("release_hold", value_out, 1'b1);
        chk_pulses("rise_after", 1'b0, 1'b0);

        // Mid-count reset discards the partial count.
        value_in = 1'b0;
        cycles(600);
        chk("midcount_pre", value_out, 1'b1);
        rst = 1'b1;
        cycles(2);
        chk_pulses("midcount_in_reset", 1'b0, 1'b0);
        rst = 1'b0;
        cycles(N + 1);
        chk("midcount_edge_N", value_out, 1'b1);
        cycles(1);
        chk("midcount_edge_N1", value_out, 1'b0);
        chk_pulses("midcount_fall", 1'b0, 1'b1);

        // Asynchronous reset between clock edges forces value_out back to 1.
        cycles(3);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async_from0", value_out, 1'b1);
        chk_pulses("reset_async", 1'b0, 1'b0);
        cycles(2);
        value_in = 1'b1;
        rst      = 1'b0;
        cycles(5);
        chk("post_reset_idle", value_out, 1'b1);
        chk_pulses("post_reset", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire
